// File: rtl/reg_spill_fill.sv
// Spill/fill sequencer for the 8-bit register file: streams every register out
// in address order (spill) or rewrites every register from an input stream (fill).
module reg_spill_fill #(
    parameter int pw = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    output logic          busy,
    output logic          done,
    output logic [pw-1:0] rf_rd_addr,
    input  logic [7:0]    rf_rd_dat,
    output logic [pw-1:0] rf_wr_addr,
    output logic          rf_wr_en,
    output logic [7:0]    rf_wr_dat,
    output logic [7:0]    spill_dat,
    output logic          spill_valid,
    input  logic          spill_ready,
    input  logic [7:0]    fill_dat,
    input  logic          fill_valid,
    output logic          fill_ready
);

    typedef enum logic [1:0] {
        IDLE,
        SPILL,
        FILL,
        DONE
    } state_t;

    localparam logic [pw:0] N_REG  = (pw + 1)'(2 ** pw);
    localparam logic [pw:0] N_LAST = (pw + 1)'(2 ** pw - 1);

    state_t      state;
    logic [pw:0] idx;
    logic        spill_arm;
    logic        spill_load;

    // The first SPILL cycle only settles the read address, so byte 0 appears
    // two cycles after the start edge rather than one.
    assign spill_load = (state == SPILL) && !spill_arm
                        && (!spill_valid || spill_ready) && (idx < N_REG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            spill_arm   <= 1'b0;
            spill_valid <= 1'b0;
            spill_dat   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx       <= '0;
                        spill_arm <= !mode;
                        state     <= mode ? FILL : SPILL;
                    end
                end
                SPILL: begin
                    if (spill_arm) begin
                        spill_arm <= 1'b0;
                    end else if (spill_load) begin
                        spill_dat   <= rf_rd_dat;
                        spill_valid <= 1'b1;
                        idx         <= idx + 1'b1;
                    end else if (spill_valid && spill_ready) begin
                        // Only reachable once idx has hit N: last byte taken.
                        spill_valid <= 1'b0;
                        if (idx == N_REG) begin
                            state <= DONE;
                        end
                    end
                end
                FILL: begin
                    if (fill_valid) begin
                        idx <= idx + 1'b1;
                        if (idx == N_LAST) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        busy       = (state != IDLE);
        done       = (state == DONE);
        fill_ready = (state == FILL);
        rf_wr_en   = fill_ready && fill_valid;
        rf_wr_addr = idx[pw-1:0];
        rf_wr_dat  = fill_ready ? fill_dat : '0;
        rf_rd_addr = idx[pw-1:0];
    end

endmodule

// File: tb/tb_reg_spill_fill.sv
// Randomised directed bench for reg_spill_fill: a pw=3 and a pw=2 instance share
// one stimulus set (gated by sel) and are checked against a register-file model.
module tb_reg_spill_fill;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       sel;
    logic       start, mode, spill_ready, fill_valid;
    logic [7:0] fill_dat;

    // pw = 3 instance
    logic       start0, spill_ready0, fill_valid0;
    logic       busy0, done0, wr_en0, spill_valid0, fill_ready0;
    logic [2:0] rd_addr0, wr_addr0;
    logic [7:0] rd_dat0, wr_dat0, spill_dat0;
    // pw = 2 instance
    logic       start1, spill_ready1, fill_valid1;
    logic       busy1, done1, wr_en1, spill_valid1, fill_ready1;
    logic [1:0] rd_addr1, wr_addr1;
    logic [7:0] rd_dat1, wr_dat1, spill_dat1;

    assign start0       = start & ~sel;
    assign spill_ready0 = spill_ready & ~sel;
    assign fill_valid0  = fill_valid & ~sel;
    assign start1       = start & sel;
    assign spill_ready1 = spill_ready & sel;
    assign fill_valid1  = fill_valid & sel;

    reg_spill_fill #(.pw(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode),
        .busy(busy0), .done(done0),
        .rf_rd_addr(rd_addr0), .rf_rd_dat(rd_dat0),
        .rf_wr_addr(wr_addr0), .rf_wr_en(wr_en0), .rf_wr_dat(wr_dat0),
        .spill_dat(spill_dat0), .spill_valid(spill_valid0), .spill_ready(spill_ready0),
        .fill_dat(fill_dat), .fill_valid(fill_valid0), .fill_ready(fill_ready0)
    );

    reg_spill_fill #(.pw(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode),
        .busy(busy1), .done(done1),
        .rf_rd_addr(rd_addr1), .rf_rd_dat(rd_dat1),
        .rf_wr_addr(wr_addr1), .rf_wr_en(wr_en1), .rf_wr_dat(wr_dat1),
        .spill_dat(spill_dat1), .spill_valid(spill_valid1), .spill_ready(spill_ready1),
        .fill_dat(fill_dat), .fill_valid(fill_valid1), .fill_ready(fill_ready1)
    );

    // Register file model (no reset) with a write counter per instance.
    logic [7:0] mem [2][8];
    int wr_cnt0 = 0;
    int wr_cnt1 = 0;
    always @(posedge clk) begin
        if (wr_en0) begin
            mem[0][wr_addr0] <= wr_dat0;
            wr_cnt0 <= wr_cnt0 + 1;
        end
        if (wr_en1) begin
            mem[1][{1'b0, wr_addr1}] <= wr_dat1;
            wr_cnt1 <= wr_cnt1 + 1;
        end
    end
    assign rd_dat0 = mem[0][rd_addr0];
    assign rd_dat1 = mem[1][{1'b0, rd_addr1}];

    // Views of the selected instance
    logic       busy_v, done_v, wr_en_v, spill_valid_v, fill_ready_v;
    logic [2:0] rd_addr_v, wr_addr_v;
    logic [7:0] wr_dat_v, spill_dat_v;
    assign busy_v        = sel ? busy1 : busy0;
    assign done_v        = sel ? done1 : done0;
    assign wr_en_v       = sel ? wr_en1 : wr_en0;
    assign spill_valid_v = sel ? spill_valid1 : spill_valid0;
    assign fill_ready_v  = sel ? fill_ready1 : fill_ready0;
    assign rd_addr_v     = sel ? {1'b0, rd_addr1} : rd_addr0;
    assign wr_addr_v     = sel ? {1'b0, wr_addr1} : wr_addr0;
    assign wr_dat_v      = sel ? wr_dat1 : wr_dat0;
    assign spill_dat_v   = sel ? spill_dat1 : spill_dat0;

    // Expected register contents, maintained from the intended stimulus
    logic [7:0] ref_mem [2][8];

    int total  = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int nreg();
        return sel ? 4 : 8;
    endfunction

    function automatic int wr_count();
        return sel ? wr_cnt1 : wr_cnt0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_mem();
        for (int i = 0; i < nreg(); i++) chk("mem_content", mem[sel][i], ref_mem[sel][i]);
    endtask

    // data_mode: 0 = 0x10,0x21,.., 1 = 0xA0+i, 2 = random
    // gap_mode : 0 = none, 1 = one gap before bytes 2 and 5, 2 = random gaps
    task automatic do_fill(input int data_mode, input int gap_mode, input int abort_after);
        logic [7:0] bytes [8];
        int  n     = nreg();
        int  sent  = 0;
        int  dn    = 0;
        int  k     = 0;
        int  wr0   = wr_count();
        bit  gapped  = 1'b0;
        bit  aborted = 1'b0;
        bit  v;
        for (int i = 0; i < 8; i++) begin
            case (data_mode)
                0:       bytes[i] = 8'(8'h10 + 8'h11 * i);
                1:       bytes[i] = 8'(8'hA0 + i);
                default: bytes[i] = 8'($urandom);
            endcase
        end
        start = 1'b1; mode = 1'b1;
        tick();
        start = 1'b0; mode = 1'b0;
        while (k < 200) begin
            if (!busy_v) break;
            if (done_v) begin
                dn++;
                chk("fill_ready_in_done", fill_ready_v, 0);
                chk("fill_done_after_n", sent, n);
            end
            if (abort_after > 0 && sent == abort_after) begin
                rst_n = 1'b0;
                #1;
                chk("abort_busy", busy_v, 0);
                chk("abort_done", done_v, 0);
                chk("abort_fill_ready", fill_ready_v, 0);
                chk("abort_wr_en", wr_en_v, 0);
                fill_valid = 1'b0;
                tick();
                rst_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            v = fill_ready_v;
            if (v && gap_mode == 1 && (sent == 2 || sent == 5) && !gapped) begin
                v = 1'b0;
                gapped = 1'b1;
            end else if (v && gap_mode == 2 && $urandom_range(0, 2) == 0) begin
                v = 1'b0;
            end
            fill_valid = v;
            fill_dat   = (sent < n) ? bytes[sent] : 8'($urandom);
            #1;
            chk("fill_wr_en", wr_en_v, v);
            if (v) begin
                chk("fill_wr_addr", wr_addr_v, sent);
                chk("fill_wr_dat", wr_dat_v, bytes[sent]);
                ref_mem[sel][sent] = bytes[sent];
                sent++;
                gapped = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
        end
        fill_valid = 1'b0;
        chk("fill_finished", busy_v, 0);
        if (aborted) begin
            chk("abort_no_done", dn, 0);
            chk("abort_write_count", wr_count() - wr0, abort_after);
        end else begin
            chk("fill_done_count", dn, 1);
            chk("fill_write_count", wr_count() - wr0, n);
        end
        check_mem();
    endtask

    // pat: 0 = ready held high, 1 = random ready, 2 = toggling with a 3-cycle stall at byte 4
    task automatic do_spill(input int pat, input bit inject);
        logic [7:0] exp_q [$];
        logic [7:0] prev_dat = '0;
        int  n       = nreg();
        int  k       = 0;
        int  got     = 0;
        int  dn      = 0;
        int  busy_n  = 0;
        int  first_k = -1;
        int  wr_seen = 0;
        int  stall   = 0;
        bit  prev_stall = 1'b0;
        bit  toggle     = 1'b1;
        bit  r;
        for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[sel][i]);
        start = 1'b1; mode = 1'b0;
        tick();
        while (k < 300) begin
            start = 1'b0; mode = 1'b0;
            if (inject && k == 4) begin
                start = 1'b1; mode = 1'b1;
            end
            if (!busy_v) break;
            busy_n++;
            if (wr_en_v) wr_seen++;
            if (prev_stall) begin
                chk("spill_hold_valid", spill_valid_v, 1);
                chk("spill_hold_dat", spill_dat_v, prev_dat);
            end
            if (spill_valid_v && first_k < 0) first_k = k;
            if (done_v) begin
                dn++;
                chk("spill_done_after_last", got, n);
                chk("spill_valid_in_done", spill_valid_v, 0);
                if (inject) begin
                    start = 1'b1; mode = 1'b0;
                end
            end
            case (pat)
                0: r = 1'b1;
                1: r = 1'($urandom_range(0, 1));
                default: begin
                    if (got == 4 && stall < 3 && spill_valid_v) begin
                        r = 1'b0;
                        stall++;
                    end else begin
                        r = toggle;
                        toggle = !toggle;
                    end
                end
            endcase
            spill_ready = r;
            if (spill_valid_v && r) begin
                if (got < n) chk("spill_byte", spill_dat_v, exp_q[got]);
                got++;
            end
            prev_stall = spill_valid_v && !r;
            prev_dat   = spill_dat_v;
            tick();
            k++;
        end
        start = 1'b0; mode = 1'b0; spill_ready = 1'b0;
        chk("spill_finished", busy_v, 0);
        chk("spill_byte_count", got, n);
        chk("spill_done_count", dn, 1);
        chk("spill_no_write", wr_seen, 0);
        if (pat == 0) begin
            chk("spill_busy_cycles", busy_n, n + 3);
            chk("spill_first_latency", first_k, 2);
        end
    endtask

    initial begin
        sel = 1'b0; start = 1'b0; mode = 1'b0; spill_ready = 1'b0;
        fill_valid = 1'b0; fill_dat = 8'h5A;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_v, 0);
        chk("rst_done", done_v, 0);
        chk("rst_spill_valid", spill_valid_v, 0);
        chk("rst_fill_ready", fill_ready_v, 0);
        chk("rst_wr_en", wr_en_v, 0);
        chk("rst_spill_dat", spill_dat_v, 0);
        chk("rst_rd_addr", rd_addr_v, 0);
        chk("rst_wr_addr", wr_addr_v, 0);
        chk("rst_wr_dat", wr_dat_v, 0);
        rst_n = 1'b1;
        tick();

        // pw = 3
        do_fill(0, 0, 0);          // preload 0x10..0x87
        do_spill(0, 1'b0);         // full-rate spill
        do_spill(2, 1'b1);         // stalls plus ignored starts
        do_fill(1, 1, 0);          // 0xA0..0xA7 with gaps at bytes 2 and 5
        do_spill(1, 1'b0);
        do_fill(2, 2, 0);
        do_spill(1, 1'b0);
        do_fill(2, 0, 3);          // reset after three writes
        do_spill(0, 1'b0);         // restarts from address 0

        // pw = 2
        sel = 1'b1;
        tick();
        do_fill(2, 2, 0);
        do_spill(0, 1'b0);
        do_spill(2, 1'b1);
        do_fill(1, 1, 0);
        do_spill(1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
